// File: rtl/fx2_pipe.sv
// FX2 fixed-point shift/rotate pipe: 128-bit big-endian lanes, 4 stages.
// Ports: issue (op/ra/imme7/rt_addr), flush, fwd2/fwd3 taps, wb port, retired_cnt.
module fx2_pipe #(
    parameter int LAT   = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [0:2]       op,
    input  logic [0:127]     ra,
    input  logic [0:6]       imme7,
    input  logic [0:6]       rt_addr,
    input  logic             flush,
    output logic             fwd2_valid,
    output logic [0:6]       fwd2_addr,
    output logic [0:127]     fwd2_data,
    output logic             fwd3_valid,
    output logic [0:6]       fwd3_addr,
    output logic [0:127]     fwd3_data,
    output logic             wb_valid,
    output logic [0:6]       wb_addr,
    output logic [0:127]     wb_data,
    output logic             wb_illegal,
    output logic [CNT_W-1:0] retired_cnt
);

    if (LAT != 4) begin : g_bad_lat
        $error("fx2_pipe supports LAT=4 only");
    end

    // Little-endian views; vector assignment keeps bit 0 as the MSB.
    logic [2:0]   w_op;
    logic [6:0]   w_imm;
    logic [6:0]   w_neg;
    logic [5:0]   w_cnt;
    logic         w_ill;
    logic [127:0] w_res;

    assign w_op  = op;
    assign w_imm = imme7;
    assign w_neg = 7'd0 - w_imm;
    assign w_ill = (w_op > 3'd4);

    logic         r1_valid, r2_valid, r3_valid, r4_valid;
    logic [2:0]   r1_op;
    logic [5:0]   r1_cnt;
    logic [127:0] r1_a;
    logic [6:0]   r1_addr, r2_addr, r3_addr, r4_addr;
    logic         r1_ill, r2_ill, r3_ill, r4_ill;
    logic [127:0] r2_data, r3_data, r4_data;
    logic [CNT_W-1:0] r_cnt;

    function automatic logic [15:0] rotl16(logic [15:0] h, logic [3:0] c);
        logic [31:0] t;
        t = {h, h} << c;
        return t[31:16];
    endfunction

    function automatic logic [31:0] rotl32(logic [31:0] w, logic [4:0] c);
        logic [63:0] t;
        t = {w, w} << c;
        return t[63:32];
    endfunction

    // Shift count is decoded at issue so S2 only sees a ready-made count.
    always_comb begin
        w_cnt = '0;
        case (w_op)
            3'd0:    w_cnt = {2'b00, w_imm[3:0]};
            3'd1:    w_cnt = {1'b0, w_imm[4:0]};
            3'd2:    w_cnt = {1'b0, w_imm[4:0]};
            3'd3:    w_cnt = w_imm[5:0];
            3'd4:    w_cnt = {1'b0, w_neg[4:0]};
            default: w_cnt = '0;
        endcase
    end

    always_comb begin
        w_res = '0;
        case (r1_op)
            3'd0:
                for (int i = 0; i < 8; i++)
                    w_res[16*i +: 16] = rotl16(r1_a[16*i +: 16], r1_cnt[3:0]);
            3'd1:
                for (int i = 0; i < 4; i++)
                    w_res[32*i +: 32] = rotl32(r1_a[32*i +: 32], r1_cnt[4:0]);
            3'd2:
                for (int i = 0; i < 8; i++)
                    w_res[16*i +: 16] = (r1_cnt >= 6'd16) ? 16'h0000
                                      : r1_a[16*i +: 16] << r1_cnt[3:0];
            3'd3:
                for (int i = 0; i < 4; i++)
                    w_res[32*i +: 32] = (r1_cnt >= 6'd32) ? 32'h0
                                      : r1_a[32*i +: 32] << r1_cnt[4:0];
            3'd4:
                for (int i = 0; i < 8; i++)
                    w_res[16*i +: 16] = (r1_cnt >= 6'd16) ? 16'h0000
                                      : r1_a[16*i +: 16] >> r1_cnt[3:0];
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r1_op    <= '0;
            r1_cnt   <= '0;
            r1_a     <= '0;
            r1_addr  <= '0;
            r1_ill   <= 1'b0;
            r2_valid <= 1'b0;
            r2_addr  <= '0;
            r2_data  <= '0;
            r2_ill   <= 1'b0;
            r3_valid <= 1'b0;
            r3_addr  <= '0;
            r3_data  <= '0;
            r3_ill   <= 1'b0;
            r4_valid <= 1'b0;
            r4_addr  <= '0;
            r4_data  <= '0;
            r4_ill   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r1_valid <= issue_valid & ~flush;
            r1_op    <= w_op;
            r1_cnt   <= w_cnt;
            r1_a     <= ra;
            r1_addr  <= rt_addr;
            r1_ill   <= w_ill;
            r2_valid <= r1_valid & ~flush;
            r2_addr  <= r1_addr;
            r2_data  <= w_res;
            r2_ill   <= r1_ill;
            // S3/S4 are past the flush point and always drain.
            r3_valid <= r2_valid;
            r3_addr  <= r2_addr;
            r3_data  <= r2_data;
            r3_ill   <= r2_ill;
            r4_valid <= r3_valid;
            r4_addr  <= r3_addr;
            r4_data  <= r3_data;
            r4_ill   <= r3_ill;
            if (r4_valid)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign fwd2_valid  = r2_valid;
    assign fwd2_addr   = r2_addr;
    assign fwd2_data   = r2_data;
    assign fwd3_valid  = r3_valid;
    assign fwd3_addr   = r3_addr;
    assign fwd3_data   = r3_data;
    assign wb_valid    = r4_valid;
    assign wb_addr     = r4_addr;
    assign wb_data     = r4_data;
    assign wb_illegal  = r4_valid & r4_ill;
    assign retired_cnt = r_cnt;

endmodule

// File: tb/tb_fx2_pipe.sv
// Directed self-checking bench for fx2_pipe.
// A narrow-counter second instance exercises retired_cnt wrap.
module tb_fx2_pipe;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         issue_valid;
    logic [0:2]   op;
    logic [0:127] ra;
    logic [0:6]   imme7;
    logic [0:6]   rt_addr;
    logic         flush;
    logic         fwd2_valid, fwd3_valid, wb_valid, wb_illegal;
    logic [0:6]   fwd2_addr, fwd3_addr, wb_addr;
    logic [0:127] fwd2_data, fwd3_data, wb_data;
    logic [31:0]  retired_cnt;

    logic         s_f2v, s_f3v, s_wbv, s_ill;
    logic [0:6]   s_f2a, s_f3a, s_wba;
    logic [0:127] s_f2d, s_f3d, s_wbd;
    logic [3:0]   s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fx2_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .op(op),
        .ra(ra), .imme7(imme7), .rt_addr(rt_addr), .flush(flush),
        .fwd2_valid(fwd2_valid), .fwd2_addr(fwd2_addr), .fwd2_data(fwd2_data),
        .fwd3_valid(fwd3_valid), .fwd3_addr(fwd3_addr), .fwd3_data(fwd3_data),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_illegal(wb_illegal), .retired_cnt(retired_cnt)
    );

    fx2_pipe #(.LAT(4), .CNT_W(4)) u_small (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .op(op),
        .ra(ra), .imme7(imme7), .rt_addr(rt_addr), .flush(flush),
        .fwd2_valid(s_f2v), .fwd2_addr(s_f2a), .fwd2_data(s_f2d),
        .fwd3_valid(s_f3v), .fwd3_addr(s_f3a), .fwd3_data(s_f3d),
        .wb_valid(s_wbv), .wb_addr(s_wba), .wb_data(s_wbd),
        .wb_illegal(s_ill), .retired_cnt(s_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] o, input logic [127:0] a,
                          input logic [6:0] im, input logic [6:0] ad);
        issue_valid = 1'b1;
        op          = o;
        ra          = a;
        imme7       = im;
        rt_addr     = ad;
    endtask

    // Issue in cycle 0, expect the writeback in cycle 4 only.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [127:0] a, input logic [6:0] im,
                          input logic [6:0] ad, input logic [127:0] exp,
                          input logic ill);
        set_op(o, a, im, ad);
        step();
        issue_valid = 1'b0;
        step();
        step();
        chk({tag, "_c3_wbv"}, {127'd0, wb_valid}, 128'd0);
        step();
        chk({tag, "_wbv"}, {127'd0, wb_valid}, 128'd1);
        chk({tag, "_data"}, wb_data, exp);
        chk({tag, "_addr"}, {121'd0, wb_addr}, {121'd0, ad});
        chk({tag, "_ill"}, {127'd0, wb_illegal}, {127'd0, ill});
        step();
        chk({tag, "_c5_wbv"}, {127'd0, wb_valid}, 128'd0);
    endtask

    logic [127:0] h8001, w8001, hffff, w0001, ones;
    logic [31:0]  base;

    initial begin
        h8001 = {8{16'h8001}};
        w8001 = {4{32'h80000001}};
        hffff = {8{16'hFFFF}};
        w0001 = {4{32'h00000001}};
        ones  = {128{1'b1}};
        rst_n = 1'b0;
        issue_valid = 1'b0;
        op = '0;
        ra = '0;
        imme7 = '0;
        rt_addr = '0;
        flush = 1'b0;
        #2;
        chk("rst_wbv", {127'd0, wb_valid}, 128'd0);
        chk("rst_wbdata", wb_data, 128'd0);
        chk("rst_cnt", {96'd0, retired_cnt}, 128'd0);
        chk("rst_fwd2v", {127'd0, fwd2_valid}, 128'd0);
        step();
        rst_n = 1'b1;
        step();

        // ROTHI latency with cycle-by-cycle tap checks.
        set_op(3'd0, h8001, 7'd1, 7'd5);
        step();
        issue_valid = 1'b0;
        chk("rothi_c1_wbv", {127'd0, wb_valid}, 128'd0);
        step();
        chk("rothi_c2_f2v", {127'd0, fwd2_valid}, 128'd1);
        chk("rothi_c2_f2d", fwd2_data, {8{16'h0003}});
        step();
        chk("rothi_c3_f3v", {127'd0, fwd3_valid}, 128'd1);
        chk("rothi_c3_f3a", {121'd0, fwd3_addr}, 128'd5);
        chk("rothi_c3_wbv", {127'd0, wb_valid}, 128'd0);
        step();
        chk("rothi_c4_wbv", {127'd0, wb_valid}, 128'd1);
        chk("rothi_c4_data", wb_data, {8{16'h0003}});
        chk("rothi_c4_addr", {121'd0, wb_addr}, 128'd5);
        chk("rothi_c4_cnt", {96'd0, retired_cnt}, 128'd0);
        step();
        chk("rothi_c5_wbv", {127'd0, wb_valid}, 128'd0);
        chk("rothi_c5_cnt", {96'd0, retired_cnt}, 128'd1);

        run_op("roti", 3'd1, w8001, 7'd4, 7'd9, {4{32'h00000018}}, 1'b0);
        run_op("shlhi15", 3'd2, hffff, 7'd15, 7'd10, {8{16'h8000}}, 1'b0);
        run_op("shlhi16", 3'd2, hffff, 7'd16, 7'd11, 128'd0, 1'b0);
        run_op("shli31", 3'd3, w0001, 7'd31, 7'd12, {4{32'h80000000}}, 1'b0);
        run_op("shli32", 3'd3, w0001, 7'd32, 7'd13, 128'd0, 1'b0);
        run_op("rothmi4", 3'd4, h8001, 7'h7C, 7'd14, {8{16'h0800}}, 1'b0);
        run_op("rothmi16", 3'd4, h8001, 7'h70, 7'd15, 128'd0, 1'b0);
        run_op("rothmi0", 3'd4, h8001, 7'h00, 7'd16, h8001, 1'b0);
        run_op("resv6", 3'd6, ones, 7'd3, 7'd127, 128'd0, 1'b1);
        chk("cnt_after_ops", {96'd0, retired_cnt}, 128'd10);

        // Back-to-back with flush in cycle 3.
        base = retired_cnt;
        set_op(3'd0, h8001, 7'd1, 7'd1);
        step();
        set_op(3'd1, w8001, 7'd4, 7'd2);
        step();
        chk("b2b_c2_f2v", {127'd0, fwd2_valid}, 128'd1);
        chk("b2b_c2_f2a", {121'd0, fwd2_addr}, 128'd1);
        chk("b2b_c2_f2d", fwd2_data, {8{16'h0003}});
        set_op(3'd2, hffff, 7'd1, 7'd3);
        step();
        chk("b2b_c3_f3a", {121'd0, fwd3_addr}, 128'd1);
        chk("b2b_c3_f3d", fwd3_data, {8{16'h0003}});
        chk("b2b_c3_f2a", {121'd0, fwd2_addr}, 128'd2);
        chk("b2b_c3_f2d", fwd2_data, {4{32'h00000018}});
        set_op(3'd3, w0001, 7'd1, 7'd4);
        flush = 1'b1;
        step();
        issue_valid = 1'b0;
        flush = 1'b0;
        chk("b2b_c4_wbv", {127'd0, wb_valid}, 128'd1);
        chk("b2b_c4_wba", {121'd0, wb_addr}, 128'd1);
        chk("b2b_c4_f3a", {121'd0, fwd3_addr}, 128'd2);
        chk("b2b_c4_f3d", fwd3_data, {4{32'h00000018}});
        chk("b2b_c4_f2v", {127'd0, fwd2_valid}, 128'd0);
        step();
        chk("b2b_c5_wbv", {127'd0, wb_valid}, 128'd1);
        chk("b2b_c5_wba", {121'd0, wb_addr}, 128'd2);
        chk("b2b_c5_wbd", wb_data, {4{32'h00000018}});
        chk("b2b_c5_f3v", {127'd0, fwd3_valid}, 128'd0);
        step();
        chk("b2b_c6_wbv", {127'd0, wb_valid}, 128'd0);
        step();
        chk("b2b_c7_wbv", {127'd0, wb_valid}, 128'd0);
        chk("b2b_cnt", {96'd0, retired_cnt}, {96'd0, base + 32'd2});

        // Asynchronous reset with three ops in flight.
        set_op(3'd0, h8001, 7'd1, 7'd20);
        step();
        step();
        step();
        issue_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wbv", {127'd0, wb_valid}, 128'd0);
        chk("arst_f2v", {127'd0, fwd2_valid}, 128'd0);
        chk("arst_f3v", {127'd0, fwd3_valid}, 128'd0);
        chk("arst_f3d", fwd3_data, 128'd0);
        chk("arst_cnt", {96'd0, retired_cnt}, 128'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("arst_post_wbv", {127'd0, wb_valid}, 128'd0);
        end
        chk("arst_post_cnt", {96'd0, retired_cnt}, 128'd0);

        // Counter wrap on the 4-bit instance.
        set_op(3'd0, h8001, 7'd1, 7'd30);
        for (int i = 0; i < 15; i++) step();
        issue_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("wrap_small15", {124'd0, s_cnt}, 128'd15);
        chk("wrap_big15", {96'd0, retired_cnt}, 128'd15);
        set_op(3'd0, h8001, 7'd1, 7'd31);
        step();
        issue_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("wrap_small0", {124'd0, s_cnt}, 128'd0);
        chk("wrap_big16", {96'd0, retired_cnt}, 128'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fx2_pipe.md
Name: fx2_pipe

Overview:
- FX2 (fixed-point shift/rotate) execution pipe of the SPU.
- Sits between the issue/operand-fetch stage and the register-file writeback port.
- Accepts one shift/rotate-immediate instruction per cycle on 128-bit big-endian operands (bit 0 = MSB), computes the result, and carries it through a 4-stage pipe to writeback.
- Exposes forwarding taps for the dependency-check logic.

Parameters:
- LAT, 4, pipe depth (fixed; stages S1..S4); other values unsupported.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  instruction presented this cycle
- op  in  [0:2]  0 ROTHI, 1 ROTI, 2 SHLHI, 3 SHLI, 4 ROTHMI, 5-7 reserved
- ra  in  [0:127]  source operand
- imme7  in  [0:6]  7-bit immediate
- rt_addr  in  [0:6]  destination register
- flush  in  1  kill younger in-flight ops
- fwd2_valid/fwd2_addr/fwd2_data  out  1/[0:6]/[0:127]  S2 contents
- fwd3_valid/fwd3_addr/fwd3_data  out  1/[0:6]/[0:127]  S3 contents
- wb_valid  out  1  writeback strobe (S4)
- wb_addr  out  [0:6]  writeback register
- wb_data  out  [0:127]  writeback data
- wb_illegal  out  1  S4 holds a reserved opcode
- retired_cnt  out  [CNT_W-1:0]  count of wb_valid cycles

Behaviour:
- Reset (async, rst_n=0): all stage valids, addresses, data, illegal flags, retired_cnt = 0 immediately; all outputs 0. Held through release; first edge after release samples normally. Reset mid-operation drops all in-flight ops.
- Pipe timing:
  - S1 registers op, ra, rt_addr and the decoded shift count.
  - S2 registers the computed 128-bit result.
  - S3 and S4 are pure delay.
  - Issue in cycle 0 → S1 cycle 1, S2 cycle 2, S3 cycle 3, wb outputs cycle 4. Throughput 1/cycle, no stall.
- Lane operations (each lane independent, left = toward bit 0):
  - ROTHI: each of 8 halfwords rotated left by imme7[3:6] (mod 16).
  - ROTI: each of 4 words rotated left by imme7[2:6] (mod 32).
  - SHLHI: each halfword shifted left by imme7[2:6], zero fill; count ≥16 → 0x0000.
  - SHLI: each word shifted left by imme7[1:6], zero fill; count ≥32 → 0.
  - ROTHMI: count = (0 − imme7) mod 32 (7-bit two's complement negate, low 5 bits); each halfword logically shifted right by count; count ≥16 → 0.
  - Reserved ops: result = 0, illegal flag set, op still flows and writes back.
- Valid tracking:
  - S1 valid ← issue_valid & ~flush.
  - S2 valid ← S1 valid & ~flush.
  - S3 ← S2, S4 ← S3 unconditionally; flush never affects S3/S4.
  - Flush with issue_valid in the same cycle: the issued op is discarded.
- Bubbles: data/addr of an invalid stage are don't-care but must not cause wb_valid or fwd*_valid.
- Forwarding:
  - fwd2_* reflect S2 registers.
  - fwd3_* reflect S3 registers.
  - Valid bits are gated by stage valid only.
- retired_cnt: +1 on each edge where S4 valid is 1; wraps at 2^CNT_W−1 → 0.

Test Plan:
- Reset/idle: assert rst_n=0 mid-stream with 3 ops in flight → all outputs 0 asynchronously; no wb after release; retired_cnt=0.
- ROTHI/ROTI latency: ROTHI with all halfwords 0x8001, imme7=1 in cycle 0 → wb_valid=1 only in cycle 4, wb_data=0x0003 in every halfword, wb_addr matches. Then ROTI with words 0x80000001, imme7=4 → 0x00000018 per word.
- Shift boundaries: SHLHI halfwords 0xFFFF, imme7=15 → 0x8000; imme7=16 → 0x0000. SHLI words 0x00000001, imme7=31 → 0x80000000; imme7=32 → 0.
- ROTHMI: halfwords 0x8001, imme7=0x7C (count 4) → 0x0800; imme7=0x70 (count 16) → 0x0000; imme7=0 (count 0) → 0x8001.
- Back-to-back + flush: issue ops A,B,C,D in cycles 0-3, flush in cycle 3 → A,B written back in cycles 4,5; C,D never appear; fwd2/fwd3 track A,B in cycles 2/3 and 3/4. retired_cnt=2.
- Reserved op: op=6, ra all ones → wb_data=0, wb_illegal=1, wb_valid=1 in cycle 4. Preload retired_cnt at 0xFFFFFFFF via a long stream → wraps to 0.
